// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle MIPS datapath: sequences the shared ALU,
// the unified memory port and the register file, and decodes the ALU operation.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regwrite,
  output logic       memtoreg,
  output logic       regdst,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11
  } state_t;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     state_reg, state_next;
  logic       pcwrite, branch;
  logic       irwrite_raw, memwrite_raw, regwrite_raw;
  logic [1:0] aluop;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_reg <= S_FETCH;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next   = S_FETCH;
    pcwrite      = 1'b0;
    branch       = 1'b0;
    iord         = 1'b0;
    memwrite_raw = 1'b0;
    irwrite_raw  = 1'b0;
    regwrite_raw = 1'b0;
    memtoreg     = 1'b0;
    regdst       = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    pcsrc        = 2'b00;
    aluop        = 2'b00;
    illegal      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        alusrcb     = 2'b01;
        irwrite_raw = mem_ready;
        pcwrite     = mem_ready;
        state_next  = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        alusrcb = 2'b11;
        case (op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_RTYPEEX;
          OP_BEQ:       state_next = S_BEQEX;
          OP_ADDI:      state_next = S_ADDIEX;
          OP_J:         state_next = S_JEX;
          default: begin
            state_next = S_FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = (op == OP_LW) ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        iord       = 1'b1;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        memtoreg     = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_MEMWR: begin
        iord         = 1'b1;
        memwrite_raw = 1'b1;
        state_next   = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_RTYPEEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        state_next = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regdst       = 1'b1;
        regwrite_raw = 1'b1;
      end
      S_BEQEX: begin
        alusrca = 1'b1;
        aluop   = 2'b01;
        pcsrc   = 2'b01;
        branch  = 1'b1;
      end
      S_ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: regwrite_raw = 1'b1;
      S_JEX: begin
        pcsrc   = 2'b10;
        pcwrite = 1'b1;
      end
      default: state_next = S_FETCH;
    endcase
  end

  always_comb begin
    alucontrol = 3'b010;
    case (aluop)
      2'b01: alucontrol = 3'b110;
      2'b10: begin
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      default: alucontrol = 3'b010;
    endcase
  end

  // Write strobes are gated by reset so an aborted instruction leaves no side effects.
  assign pcen     = (pcwrite | (branch & zero)) & reset;
  assign irwrite  = irwrite_raw & reset;
  assign memwrite = memwrite_raw & reset;
  assign regwrite = regwrite_raw & reset;
  assign state    = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized scoreboard bench for multicycle_controller: the stimulus pushes the
// expected per-cycle control word, a monitor pops and compares on each falling edge.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, mem_ready;
  logic       pcen, iord, memwrite, irwrite, regwrite, memtoreg, regdst, alusrca, illegal;
  logic [1:0] alusrcb, pcsrc;
  logic [2:0] alucontrol;
  logic [3:0] state;

  int passed = 0;
  int total  = 0;
  logic [19:0] exp_q[$];
  logic [19:0] dut_vec;

  always #5 clk = ~clk;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
    .pcen(pcen), .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
    .memtoreg(memtoreg), .regdst(regdst), .alusrca(alusrca), .alusrcb(alusrcb),
    .pcsrc(pcsrc), .alucontrol(alucontrol), .illegal(illegal), .state(state)
  );

  assign dut_vec = {state, pcen, iord, memwrite, irwrite, regwrite, memtoreg, regdst,
                    alusrca, alusrcb, pcsrc, alucontrol, illegal};

  function automatic bit is_legal(logic [5:0] o);
    return (o == 6'd35) || (o == 6'd43) || (o == 6'd0) || (o == 6'd4) ||
           (o == 6'd8) || (o == 6'd2);
  endfunction

  // Expected control word for one cycle spent in step st of an instruction.
  function automatic logic [19:0] model(int st, logic [5:0] o, logic [5:0] f, logic z, logic mr);
    logic e_pcen, e_iord, e_mw, e_ir, e_rw, e_m2r, e_rd, e_a, e_ill;
    logic [1:0] e_b, e_pcsrc;
    logic [2:0] e_alu;
    {e_pcen, e_iord, e_mw, e_ir, e_rw, e_m2r, e_rd, e_a, e_ill} = 9'b0;
    e_b = 2'b00; e_pcsrc = 2'b00; e_alu = 3'b010;
    case (st)
      0:  begin e_b = 2'b01; e_ir = mr; e_pcen = mr; end
      1:  begin e_b = 2'b11; e_ill = !is_legal(o); end
      2:  begin e_a = 1'b1; e_b = 2'b10; end
      3:  e_iord = 1'b1;
      4:  begin e_m2r = 1'b1; e_rw = 1'b1; end
      5:  begin e_iord = 1'b1; e_mw = 1'b1; end
      6: begin
        e_a = 1'b1;
        if (f == 6'd34) e_alu = 3'b110;
        else if (f == 6'd36) e_alu = 3'b000;
        else if (f == 6'd37) e_alu = 3'b001;
        else if (f == 6'd42) e_alu = 3'b111;
      end
      7:  begin e_rd = 1'b1; e_rw = 1'b1; end
      8:  begin e_a = 1'b1; e_alu = 3'b110; e_pcsrc = 2'b01; e_pcen = z; end
      9:  begin e_a = 1'b1; e_b = 2'b10; end
      10: e_rw = 1'b1;
      11: begin e_pcsrc = 2'b10; e_pcen = 1'b1; end
      default: ;
    endcase
    return {4'(st), e_pcen, e_iord, e_mw, e_ir, e_rw, e_m2r, e_rd, e_a, e_b, e_pcsrc, e_alu, e_ill};
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] want);
    total++;
    if (got === want) passed++;
    else $display("FAIL %s got=%h expected=%h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1 && exp_q.size() > 0) begin
      logic [19:0] want;
      want = exp_q.pop_front();
      total++;
      if (dut_vec === want) passed++;
      else $display("FAIL cycle_word state=%0d got=%h expected=%h", want[19:16], dut_vec, want);
    end
  end

  // zm: 0/1 force zero, 2 random. Entered and left #1 after a rising edge in FETCH.
  task automatic run_instr(logic [5:0] o, logic [5:0] f, int sf, int sm, int zm, bit abort);
    int seq[$];
    int mrs[$];
    int mem_st;
    for (int i = 0; i < sf; i++) begin seq.push_back(0); mrs.push_back(0); end
    seq.push_back(0); mrs.push_back(1);
    seq.push_back(1); mrs.push_back(int'($urandom_range(0, 1)));
    mem_st = -1;
    case (o)
      6'd35: begin seq.push_back(2); mrs.push_back(int'($urandom_range(0, 1))); mem_st = 3; end
      6'd43: begin seq.push_back(2); mrs.push_back(int'($urandom_range(0, 1))); mem_st = 5; end
      6'd0:  begin seq.push_back(6); seq.push_back(7); mrs.push_back(0); mrs.push_back(1); end
      6'd4:  begin seq.push_back(8); mrs.push_back(int'($urandom_range(0, 1))); end
      6'd8:  begin seq.push_back(9); seq.push_back(10); mrs.push_back(1); mrs.push_back(0); end
      6'd2:  begin seq.push_back(11); mrs.push_back(int'($urandom_range(0, 1))); end
      default: ;
    endcase
    if (mem_st >= 0) begin
      for (int i = 0; i < sm; i++) begin seq.push_back(mem_st); mrs.push_back(0); end
      seq.push_back(mem_st); mrs.push_back(1);
      if (mem_st == 3) begin seq.push_back(4); mrs.push_back(int'($urandom_range(0, 1))); end
    end
    $display("instr op=%b funct=%b fetch_stall=%0d mem_stall=%0d cycles=%0d abort=%0d",
             o, f, sf, sm, seq.size(), abort);
    for (int i = 0; i < seq.size(); i++) begin
      op = o; funct = f;
      mem_ready = mrs[i][0];
      zero = (zm == 2) ? 1'($urandom_range(0, 1)) : zm[0];
      if (abort && seq[i] == 3) begin
        mem_ready = 1'b0;
        exp_q.push_back(model(3, o, f, zero, 1'b0));
        @(negedge clk);
        #2 reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
        repeat (3) begin
          @(negedge clk);
          chk("abort_hold", 32'({state, pcen, irwrite, memwrite, regwrite}), 32'd0);
        end
        @(posedge clk);
        #1 reset = 1'b1;
        return;
      end
      exp_q.push_back(model(seq[i], o, f, zero, mem_ready));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [5:0] o, f;
    int k;
    reset = 1'b0; mem_ready = 1'b1; op = 6'd35; funct = 6'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(state), 32'd0);
    chk("reset_strobes", 32'({pcen, irwrite, memwrite, regwrite}), 32'd0);
    chk("reset_fetch_sel", 32'({iord, alusrca, alusrcb, pcsrc, alucontrol}), 32'b0_0_01_00_010);
    @(posedge clk);
    #1 reset = 1'b1;

    run_instr(6'd35, 6'd0,  0, 0, 2, 1'b0);  // lw
    run_instr(6'd43, 6'd0,  0, 3, 2, 1'b0);  // sw, memwrite held 4 cycles
    run_instr(6'd0,  6'd42, 0, 0, 2, 1'b0);  // slt
    run_instr(6'd0,  6'd34, 0, 0, 2, 1'b0);  // sub
    run_instr(6'd4,  6'd0,  0, 0, 1, 1'b0);  // beq taken
    run_instr(6'd4,  6'd0,  0, 0, 0, 1'b0);  // beq not taken
    run_instr(6'd63, 6'd0,  0, 0, 2, 1'b0);  // illegal
    run_instr(6'd35, 6'd0,  2, 2, 2, 1'b1);  // reset during MEMRD
    run_instr(6'd8,  6'd0,  1, 0, 2, 1'b0);  // addi
    run_instr(6'd2,  6'd0,  0, 0, 2, 1'b0);  // j

    for (int n = 0; n < 200; n++) begin
      k = int'($urandom_range(0, 6));
      case (k)
        0: o = 6'd35;
        1: o = 6'd43;
        2: o = 6'd0;
        3: o = 6'd4;
        4: o = 6'd8;
        5: o = 6'd2;
        default: begin
          o = 6'($urandom);
          while (is_legal(o)) o = 6'($urandom);
        end
      endcase
      case ($urandom_range(0, 5))
        0: f = 6'd32;
        1: f = 6'd34;
        2: f = 6'd36;
        3: f = 6'd37;
        4: f = 6'd42;
        default: f = 6'($urandom);
      endcase
      run_instr(o, f, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2, 1'b0);
    end

    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multicycle MIPS variant of the core: a Moore state machine that sequences one shared ALU, one unified instruction/data memory port and the register file over several cycles per instruction. It sits beside the multicycle datapath, decodes the latched instruction's `op`/`funct`, and drives every datapath enable and mux select each cycle. A memory-ready handshake stretches memory states for slow memory.

## Interface
- No parameters (opcode set and ALU encoding fixed).
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-low (0 = in reset).
- `op` in 6: instr[31:26] from instruction register.
- `funct` in 6: instr[5:0] from instruction register.
- `zero` in 1: ALU zero flag.
- `mem_ready` in 1: memory completes the current access this cycle.
- `pcen` out 1: PC register enable, = `pcwrite | (branch & zero)`.
- `iord` out 1: memory address select, 0 = PC, 1 = ALUOut.
- `memwrite` out 1: memory write strobe.
- `irwrite` out 1: instruction register load.
- `regwrite` out 1: register file write.
- `memtoreg` out 1: writeback select, 1 = data register.
- `regdst` out 1: dest select, 1 = rd, 0 = rt.
- `alusrca` out 1: 0 = PC, 1 = register A.
- `alusrcb` out 2: 00 = B, 01 = 4, 10 = signimm, 11 = signimm<<2.
- `pcsrc` out 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alucontrol` out 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `illegal` out 1: one-cycle pulse in DECODE for an unsupported opcode.
- `state` out 4: current state, debug.

## Operation
- States/encoding: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTYPEEX 6, RTYPEWB 7, BEQEX 8, ADDIEX 9, ADDIWB 10, JEX 11; codes 12–15 go to FETCH.
- Outputs not listed for a state are 0; aluop 00.
- FETCH: iord 0, alusrca 0, alusrcb 01, aluop 00, pcsrc 00; irwrite = pcwrite = `mem_ready`. Stay while `mem_ready`=0, else DECODE.
- DECODE: alusrca 0, alusrcb 11, aluop 00. Next by op: 100011 lw / 101011 sw → MEMADR; 000000 → RTYPEEX; 000100 → BEQEX; 001000 → ADDIEX; 000010 → JEX; other → FETCH, `illegal`=1.
- MEMADR: alusrca 1, alusrcb 10, aluop 00. Next: op 100011 → MEMRD, else MEMWR.
- MEMRD: iord 1. Stay while `mem_ready`=0, else MEMWB.
- MEMWB: regdst 0, memtoreg 1, regwrite 1 → FETCH.
- MEMWR: iord 1, memwrite 1 held every cycle until `mem_ready`=1 → FETCH.
- RTYPEEX: alusrca 1, alusrcb 00, aluop 10 → RTYPEWB.
- RTYPEWB: regdst 1, memtoreg 0, regwrite 1 → FETCH.
- BEQEX: alusrca 1, alusrcb 00, aluop 01, pcsrc 01, branch 1 → FETCH.
- ADDIEX: alusrca 1, alusrcb 10, aluop 00 → ADDIWB.
- ADDIWB: regdst 0, memtoreg 0, regwrite 1 → FETCH.
- JEX: pcsrc 10, pcwrite 1 → FETCH.
- ALU decode: aluop 00 → 010; 01 → 110; 10 → by funct: 100000→010, 100010→110, 100100→000, 100101→001, 101010→111, other→010; 11 → 010.

## Timing
- Only `state` is registered (4 flops); all outputs combinational from state, op, funct, zero, mem_ready.
- `reset`=0: state → FETCH immediately (async). While low, pcen, irwrite, memwrite, regwrite forced 0; other outputs = FETCH values.
- First transition on the first rising edge after `reset` returns to 1.
- Cycles per instruction with `mem_ready` tied 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2. Each `mem_ready`=0 cycle in FETCH/MEMRD/MEMWR adds one.
- `pcen` in BEQEX follows `zero` in the same cycle; no registering.
- Reset asserted mid-instruction aborts it; no partial register or memory write after reset asserts.

## Test plan
- Reset: hold `reset`=0 with `mem_ready`=1 → state 0, pcen/irwrite/memwrite/regwrite 0. Release → FETCH asserts irwrite=pcen=1, next cycle state 1.
- lw (op 100011), `mem_ready`=1 → states 0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in state 4. alucontrol 010 in state 2.
- sw with `mem_ready` low 3 cycles in MEMWR → memwrite=1 for 4 consecutive cycles, then FETCH. regwrite never 1.
- R-type funct 101010 → RTYPEEX alucontrol 111; RTYPEWB regdst=1, regwrite=1. Repeat funct 100010 → 110.
- beq: `zero`=1 → pcen=1, pcsrc 01, alucontrol 110. `zero`=0 → pcen=0. Both return to FETCH after 3 cycles.
- op 111111 → `illegal` pulses 1 cycle in DECODE, then FETCH. Separately, reset asserted in MEMRD → state 0 asynchronously and regwrite never asserts.
